// File: rtl/flash_spi_if.sv
// Command handshake between the status poller and the flash SPI master.
// Latency: none; plain wires grouped for port hygiene.
// Backpressure: the SPI master signals readiness through m_busy and the completed levels.
interface flash_spi_if;
    logic [7:0] m_opcode;
    logic       m_addr_flag;
    logic       m_opcode_addr_trigger;
    logic       m_opcode_addr_completed;
    logic       m_data_trigger;
    logic       m_data_completed;
    logic [7:0] m_read_data;
    logic       m_finalize_trigger;
    logic       m_busy;

    // Poller side: drives the opcode/data/finalize triggers.
    modport master (
        output m_opcode,
        output m_addr_flag,
        output m_opcode_addr_trigger,
        output m_data_trigger,
        output m_finalize_trigger,
        input  m_opcode_addr_completed,
        input  m_data_completed,
        input  m_read_data,
        input  m_busy
    );

    // SPI master side: answers the triggers.
    modport slave (
        input  m_opcode,
        input  m_addr_flag,
        input  m_opcode_addr_trigger,
        input  m_data_trigger,
        input  m_finalize_trigger,
        output m_opcode_addr_completed,
        output m_data_completed,
        output m_read_data,
        output m_busy
    );
endinterface

// File: rtl/flash_status_poller.sv
// Repeats RDSR (0x05) through the SPI master until WIP clears or MAX_POLLS is reached.
// Latency: start to opcode trigger is 2 clocks with an idle master; POLL_INTERVAL clocks between polls.
// Backpressure: waits on m_busy before each transaction and before leaving a finalize phase.
module flash_status_poller #(
    parameter int POLL_INTERVAL = 1000,
    parameter int MAX_POLLS     = 65535,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       active,
    output logic       done,
    output logic       timeout,
    output logic       flash_busy,
    output logic       flash_wel,
    output logic [7:0] status_reg,
    flash_spi_if.master m
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_OPC,
        ST_DATA,
        ST_FIN,
        ST_GAP,
        ST_DONE,
        ST_FIN_ABORT
    } state_t;

    // An interval of 0 or 1 both mean a single gap clock.
    localparam logic [CNT_W-1:0] GAP_LAST = (POLL_INTERVAL <= 1) ? '0 : CNT_W'(POLL_INTERVAL - 1);
    localparam logic [CNT_W-1:0] POLL_MAX = CNT_W'(MAX_POLLS);

    state_t           state_q;
    state_t           state_d;
    logic             opc_cmp_q;
    logic             dat_cmp_q;
    logic             opc_rise;
    logic             dat_rise;
    logic [CNT_W-1:0] poll_cnt;
    logic [CNT_W-1:0] int_cnt;
    logic             fin_ready;
    logic             fin_timeout;
    logic             latch_sr;

    // Only 0->1 transitions of the completed levels advance the FSM.
    assign opc_rise = m.m_opcode_addr_completed & ~opc_cmp_q;
    assign dat_rise = m.m_data_completed & ~dat_cmp_q;

    // Finalize phase decisions, evaluated once the master has gone idle.
    assign fin_ready   = (state_q == ST_FIN) && !m.m_busy;
    assign fin_timeout = fin_ready && flash_busy && (poll_cnt >= POLL_MAX);
    assign latch_sr    = (state_q == ST_DATA) && !abort && dat_rise;

    // Previous-cycle copies of the completed inputs for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            opc_cmp_q <= 1'b0;
            dat_cmp_q <= 1'b0;
        end else begin
            opc_cmp_q <= m.m_opcode_addr_completed;
            dat_cmp_q <= m.m_data_completed;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort takes priority over progress in every abortable state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!m.m_busy) begin
                    state_d = ST_OPC;
                end
            end
            ST_OPC: begin
                if (abort) begin
                    state_d = ST_FIN_ABORT;
                end else if (opc_rise) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (abort) begin
                    state_d = ST_FIN_ABORT;
                end else if (dat_rise) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                if (fin_ready) begin
                    if (!flash_busy || fin_timeout) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (int_cnt >= GAP_LAST) begin
                    state_d = ST_ARB;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FIN_ABORT: begin
                if (!m.m_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs; finalize is high in every state without a live trigger.
    always_comb begin
        active                  = 1'b1;
        done                    = 1'b0;
        m.m_opcode              = 8'h05;
        m.m_addr_flag           = 1'b0;
        m.m_opcode_addr_trigger = 1'b0;
        m.m_data_trigger        = 1'b0;
        m.m_finalize_trigger    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                active = 1'b0;
            end
            ST_OPC: begin
                m.m_opcode_addr_trigger = 1'b1;
                m.m_finalize_trigger    = 1'b0;
            end
            ST_DATA: begin
                m.m_opcode_addr_trigger = 1'b1;
                m.m_data_trigger        = 1'b1;
                m.m_finalize_trigger    = 1'b0;
            end
            ST_DONE: begin
                active = 1'b0;
                done   = 1'b1;
            end
            default: begin
                active = 1'b1;
            end
        endcase
    end

    // Status capture, poll accounting and the inter-poll gap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout    <= 1'b0;
            flash_busy <= 1'b0;
            flash_wel  <= 1'b0;
            status_reg <= 8'h00;
            poll_cnt   <= '0;
            int_cnt    <= '0;
        end else begin
            if ((state_q == ST_IDLE) && start) begin
                timeout  <= 1'b0;
                poll_cnt <= '0;
            end
            if (latch_sr) begin
                status_reg <= m.m_read_data;
                flash_busy <= m.m_read_data[0];
                flash_wel  <= m.m_read_data[1];
                if (poll_cnt < POLL_MAX) begin
                    poll_cnt <= poll_cnt + CNT_W'(1);
                end
            end
            if (fin_timeout) begin
                timeout <= 1'b1;
            end
            if ((state_q == ST_FIN) && (state_d == ST_GAP)) begin
                int_cnt <= '0;
            end else if (state_q == ST_GAP) begin
                int_cnt <= int_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_flash_status_poller.sv
// Directed bench for flash_status_poller with a behavioural SPI master model.
// Latency: checks the 2-clock start-to-trigger path and the poll gap.
// Backpressure: exercises m_busy holding off the first trigger.
`timescale 1ns/1ps
module tb_flash_status_poller;

    localparam int PI = 10;
    localparam int MP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       active;
    logic       done;
    logic       timeout;
    logic       flash_busy;
    logic       flash_wel;
    logic [7:0] status_reg;
    logic       model_busy;
    logic       ext_busy;

    flash_spi_if bus();
    assign bus.m_busy = model_busy | ext_busy;

    flash_status_poller #(.POLL_INTERVAL(PI), .MAX_POLLS(MP), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .active     (active),
        .done       (done),
        .timeout    (timeout),
        .flash_busy (flash_busy),
        .flash_wel  (flash_wel),
        .status_reg (status_reg),
        .m          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scenario setup owned by the test sequence.
    logic [7:0] sr_seq [4];
    int         sr_len;
    int         gen;
    int         data_delay;

    // State owned by the master model and monitor.
    int txn_total;
    int gap_min;
    int done_total;
    int overlap_total;
    int m_st, m_cnt, m_idx, m_gen, m_fin;
    bit m_prev;

    // Counts done pulses and any trigger/finalize overlap.
    initial begin
        done_total    = 0;
        overlap_total = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_total++;
            if (((bus.m_opcode_addr_trigger | bus.m_data_trigger) & bus.m_finalize_trigger) === 1'b1)
                overlap_total++;
        end
    end

    // SPI master model: opcode done after 3 clocks, data after data_delay, CS close takes 2 clocks.
    initial begin
        model_busy = 1'b0;
        bus.m_opcode_addr_completed = 1'b0;
        bus.m_data_completed = 1'b0;
        bus.m_read_data = 8'h00;
        txn_total = 0;
        gap_min = 1000;
        m_st = 0; m_cnt = 0; m_idx = 0; m_gen = 0; m_fin = 0; m_prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (gen != m_gen) begin
                m_gen = gen; m_idx = 0; m_prev = 1'b0; gap_min = 1000;
            end
            if (bus.m_finalize_trigger === 1'b1) m_fin++;
            case (m_st)
                0: if (bus.m_opcode_addr_trigger === 1'b1) begin
                    txn_total++;
                    if (m_prev && m_fin < gap_min) gap_min = m_fin;
                    m_prev = 1'b1; m_fin = 0;
                    model_busy = 1'b1; m_cnt = 0; m_st = 1;
                end
                1: if (bus.m_finalize_trigger === 1'b1) m_st = 4;
                   else begin
                       m_cnt++;
                       if (m_cnt == 3) begin bus.m_opcode_addr_completed = 1'b1; m_st = 2; end
                   end
                2: if (bus.m_finalize_trigger === 1'b1) m_st = 4;
                   else if (bus.m_data_trigger === 1'b1) begin m_cnt = 0; m_st = 3; end
                3: if (bus.m_finalize_trigger === 1'b1) m_st = 4;
                   else begin
                       m_cnt++;
                       if (m_cnt >= data_delay) begin
                           bus.m_read_data = sr_seq[m_idx];
                           if (m_idx < sr_len - 1) m_idx++;
                           bus.m_data_completed = 1'b1;
                           m_st = 4;
                       end
                   end
                4: if (bus.m_finalize_trigger === 1'b1) begin
                    bus.m_opcode_addr_completed = 1'b0;
                    bus.m_data_completed = 1'b0;
                    m_cnt = 0; m_st = 5;
                end
                default: begin
                    m_cnt++;
                    if (m_cnt == 2) begin model_busy = 1'b0; m_st = 0; end
                end
            endcase
        end
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string nm);
        int n = 0;
        while (done !== 1'b1 && n < maxc) begin tick(); n++; end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s: done not seen within %0d cycles, done=%b", nm, maxc, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); tick();
        checks++;
        if ({active, done, timeout, flash_busy, flash_wel, bus.m_opcode_addr_trigger, bus.m_data_trigger,
             bus.m_finalize_trigger, bus.m_addr_flag} !== 9'b000000010) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000010", {active, done, timeout, flash_busy, flash_wel,
                     bus.m_opcode_addr_trigger, bus.m_data_trigger, bus.m_finalize_trigger, bus.m_addr_flag});
        end
        checks++;
        if (status_reg !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected 00", status_reg); end
        checks++;
        if (bus.m_opcode !== 8'h05) begin errors++; $display("FAIL reset_opcode: got %h expected 05", bus.m_opcode); end
        rst = 1'b0; tick();
    endtask

    task automatic test_single();
        int d0 = done_total;
        int t0;
        gen++; sr_seq[0] = 8'h00; sr_len = 1; t0 = txn_total;
        pulse_start();
        checks++;
        if (active !== 1'b1 || bus.m_opcode_addr_trigger !== 1'b0) begin
            errors++; $display("FAIL single_lat1: active=%b trig=%b expected 1 0", active, bus.m_opcode_addr_trigger);
        end
        tick();
        checks++;
        if (bus.m_opcode_addr_trigger !== 1'b1) begin
            errors++; $display("FAIL single_lat2: trig=%b expected 1", bus.m_opcode_addr_trigger);
        end
        wait_done(100, "single_done");
        tick();
        checks++;
        if (status_reg !== 8'h00 || flash_busy !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL single_status: sr=%h busy=%b to=%b expected 00 0 0", status_reg, flash_busy, timeout);
        end
        checks++;
        if (txn_total - t0 !== 1 || done_total - d0 !== 1) begin
            errors++; $display("FAIL single_counts: txn=%0d done=%0d expected 1 1", txn_total - t0, done_total - d0);
        end
        checks++;
        if (active !== 1'b0 || bus.m_finalize_trigger !== 1'b1) begin
            errors++; $display("FAIL single_idle: active=%b fin=%b expected 0 1", active, bus.m_finalize_trigger);
        end
    endtask

    task automatic test_multi();
        int d0 = done_total;
        int t0;
        gen++; sr_seq[0] = 8'h03; sr_seq[1] = 8'h03; sr_seq[2] = 8'h02; sr_len = 3; t0 = txn_total;
        pulse_start();
        wait_done(600, "multi_done");
        tick();
        checks++;
        if (txn_total - t0 !== 3) begin errors++; $display("FAIL multi_txn: got %0d expected 3", txn_total - t0); end
        checks++;
        if (gap_min < PI) begin errors++; $display("FAIL multi_gap: min gap %0d expected >= %0d", gap_min, PI); end
        checks++;
        if (flash_wel !== 1'b1 || flash_busy !== 1'b0 || status_reg !== 8'h02) begin
            errors++; $display("FAIL multi_flags: wel=%b busy=%b sr=%h expected 1 0 02", flash_wel, flash_busy, status_reg);
        end
        checks++;
        if (done_total - d0 !== 1 || timeout !== 1'b0) begin
            errors++; $display("FAIL multi_done_cnt: done=%0d to=%b expected 1 0", done_total - d0, timeout);
        end
    endtask

    task automatic test_timeout();
        int d0 = done_total;
        int t0;
        gen++; sr_seq[0] = 8'h01; sr_len = 1; t0 = txn_total;
        pulse_start();
        wait_done(800, "timeout_done");
        tick();
        checks++;
        if (txn_total - t0 !== MP) begin errors++; $display("FAIL timeout_txn: got %0d expected %0d", txn_total - t0, MP); end
        checks++;
        if (timeout !== 1'b1 || flash_busy !== 1'b1 || status_reg !== 8'h01) begin
            errors++; $display("FAIL timeout_flags: to=%b busy=%b sr=%h expected 1 1 01", timeout, flash_busy, status_reg);
        end
        pulse_start();
        checks++;
        if (timeout !== 1'b0 || active !== 1'b1) begin
            errors++; $display("FAIL timeout_clear: to=%b active=%b expected 0 1", timeout, active);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        checks++;
        if (active !== 1'b0 || bus.m_opcode_addr_trigger !== 1'b0 || bus.m_finalize_trigger !== 1'b1) begin
            errors++; $display("FAIL abort_arb: active=%b trig=%b fin=%b expected 0 0 1",
                               active, bus.m_opcode_addr_trigger, bus.m_finalize_trigger);
        end
        tick(); tick();
        checks++;
        if (txn_total - t0 !== MP || done_total - d0 !== 1) begin
            errors++; $display("FAIL abort_arb_counts: txn=%0d done=%0d expected %0d 1", txn_total - t0, done_total - d0, MP);
        end
    endtask

    task automatic test_abort_data();
        int d0 = done_total;
        int t0;
        int n = 0;
        gen++; sr_seq[0] = 8'h00; sr_len = 1; data_delay = 30;
        pulse_start();
        while (bus.m_data_trigger !== 1'b1 && n < 50) begin tick(); n++; end
        checks++;
        if (bus.m_data_trigger !== 1'b1) begin errors++; $display("FAIL abort_reach_data: dtrig=%b expected 1", bus.m_data_trigger); end
        tick(); tick(); tick();
        abort = 1'b1; tick(); abort = 1'b0;
        checks++;
        if ({bus.m_opcode_addr_trigger, bus.m_data_trigger, bus.m_finalize_trigger, active} !== 4'b0011) begin
            errors++; $display("FAIL abort_data_outs: trig,dtrig,fin,active=%b expected 0011",
                               {bus.m_opcode_addr_trigger, bus.m_data_trigger, bus.m_finalize_trigger, active});
        end
        n = 0;
        while (active !== 1'b0 && n < 20) begin tick(); n++; end
        tick();
        checks++;
        if (active !== 1'b0 || done_total - d0 !== 0) begin
            errors++; $display("FAIL abort_data_end: active=%b done=%0d expected 0 0", active, done_total - d0);
        end
        checks++;
        if (status_reg !== 8'h01 || flash_busy !== 1'b1) begin
            errors++; $display("FAIL abort_keep_flags: sr=%h busy=%b expected 01 1", status_reg, flash_busy);
        end
        data_delay = 3; gen++; t0 = txn_total;
        pulse_start();
        wait_done(100, "abort_fresh_done");
        tick();
        checks++;
        if (status_reg !== 8'h00 || flash_busy !== 1'b0 || txn_total - t0 !== 1) begin
            errors++; $display("FAIL abort_fresh: sr=%h busy=%b txn=%0d expected 00 0 1", status_reg, flash_busy, txn_total - t0);
        end
    endtask

    task automatic test_busy_hold();
        int d0 = done_total;
        int t0;
        int bad = 0;
        gen++; sr_seq[0] = 8'h03; sr_seq[1] = 8'h02; sr_len = 2; t0 = txn_total;
        ext_busy = 1'b1;
        pulse_start();
        for (int i = 0; i < 19; i++) begin
            tick();
            if (bus.m_opcode_addr_trigger !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL busy_hold: trigger seen %0d cycles expected 0", bad); end
        ext_busy = 1'b0; tick();
        checks++;
        if (bus.m_opcode_addr_trigger !== 1'b1) begin
            errors++; $display("FAIL busy_release: trig=%b expected 1", bus.m_opcode_addr_trigger);
        end
        pulse_start();
        wait_done(400, "busy_done");
        tick();
        checks++;
        if (txn_total - t0 !== 2 || done_total - d0 !== 1 || status_reg !== 8'h02) begin
            errors++; $display("FAIL busy_second_start: txn=%0d done=%0d sr=%h expected 2 1 02",
                               txn_total - t0, done_total - d0, status_reg);
        end
    endtask

    task automatic test_rst_opc();
        gen++; sr_seq[0] = 8'h00; sr_len = 1;
        pulse_start(); tick();
        checks++;
        if (bus.m_opcode_addr_trigger !== 1'b1) begin
            errors++; $display("FAIL rst_pre_opc: trig=%b expected 1", bus.m_opcode_addr_trigger);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({active, done, timeout, flash_busy, flash_wel, bus.m_opcode_addr_trigger, bus.m_data_trigger,
             bus.m_finalize_trigger, bus.m_addr_flag} !== 9'b000000010 || status_reg !== 8'h00) begin
            errors++; $display("FAIL rst_opc: flags=%b sr=%h expected 000000010 00", {active, done, timeout, flash_busy,
                     flash_wel, bus.m_opcode_addr_trigger, bus.m_data_trigger, bus.m_finalize_trigger, bus.m_addr_flag},
                     status_reg);
        end
        for (int i = 0; i < 6; i++) tick();
        pulse_start(); tick();
        checks++;
        if (bus.m_opcode_addr_trigger !== 1'b1) begin
            errors++; $display("FAIL rst_restart: trig=%b expected 1", bus.m_opcode_addr_trigger);
        end
        wait_done(100, "rst_restart_done");
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; ext_busy = 1'b0;
        data_delay = 3; gen = 0; sr_len = 1;
        sr_seq[0] = 8'h00; sr_seq[1] = 8'h00; sr_seq[2] = 8'h00; sr_seq[3] = 8'h00;
        test_reset();
        test_single();
        test_multi();
        test_timeout();
        test_abort_data();
        test_busy_hold();
        test_rst_opc();
        checks++;
        if (overlap_total !== 0) begin
            errors++; $display("FAIL trig_fin_overlap: %0d cycles expected 0", overlap_total);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_status_poller.md
Name: flash_status_poller

Overview:
Polls the SPI flash status register (RDSR, opcode 0x05) through the flash SPI master's opcode/data trigger handshake until WIP clears, then reports completion. It sits between the controller and the flash SPI master. It is used after WREN/PROGRAM/ERASE so the controller can drive `flash_busy` and `flash_wel` from real flash state. While `active`=1 the poller owns the master's command inputs, and the controller muxes them through.

Parameters:
- POLL_INTERVAL, 1000: idle clocks between the end of one RDSR transaction and the next.
- MAX_POLLS, 65535: maximum RDSR transactions before declaring timeout. Range 1..2^CNT_W-1.
- CNT_W, 16: width of the interval and poll counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request to begin polling
- abort  in  1  one-cycle request to stop polling
- active  out  1  poller owns the master interface
- done  out  1  one-cycle pulse at the end of polling (success or timeout)
- timeout  out  1  last run hit MAX_POLLS with WIP still set
- flash_busy  out  1  last sampled WIP (SR bit0)
- flash_wel  out  1  last sampled WEL (SR bit1)
- status_reg  out  8  last full status byte read
- m_opcode  out  8  opcode to master; constant 8'h05
- m_addr_flag  out  1  constant 0 (RDSR has no address)
- m_opcode_addr_trigger  out  1  level: send opcode
- m_opcode_addr_completed  in  1  master: opcode phase done
- m_data_trigger  out  1  level: clock one data byte
- m_data_completed  in  1  master: data byte done; m_read_data valid
- m_read_data  in  8  byte shifted in from MISO
- m_finalize_trigger  out  1  level: deassert CS and return master to idle
- m_busy  in  1  master interface busy

Behaviour:
- Reset values: active=0, done=0, timeout=0, flash_busy=0, flash_wel=0, status_reg=8'h00, m_opcode=8'h05, m_addr_flag=0, m_opcode_addr_trigger=0, m_data_trigger=0, m_finalize_trigger=1, FSM=IDLE, counters=0.
- Rst wins over every other input in the same cycle. Rst during a transaction forces m_finalize_trigger=1, so the master closes CS.
- Completed inputs are edge-detected internally from previous-cycle registers. Only 0→1 transitions count.
- FSM states:
  - IDLE: m_finalize_trigger=1, active=0. On start → ARB; in the same edge clear timeout, poll_cnt=0, active=1.
  - ARB: wait for m_busy=0. Then m_finalize_trigger=0, m_opcode_addr_trigger=1 → OPC. Start-to-trigger latency is 2 clocks when the master is idle.
  - OPC: on rising m_opcode_addr_completed, set m_data_trigger=1 → DATA.
  - DATA: on rising m_data_completed, latch status_reg=m_read_data, flash_busy=bit0, flash_wel=bit1; poll_cnt+=1. Then drop both triggers, set m_finalize_trigger=1 → FIN.
  - FIN: wait for m_busy=0. Then:
    - WIP=0 → DONE.
    - WIP=1 and poll_cnt==MAX_POLLS → timeout=1 → DONE.
    - Otherwise int_cnt=0 → GAP.
  - GAP: int_cnt increments each clock. When int_cnt==POLL_INTERVAL-1 → ARB. POLL_INTERVAL=0 behaves as 1.
  - DONE: done=1 for exactly one clock, active=0 → IDLE.
- start while active=1 is ignored.
- abort while active=1:
  - In ARB or GAP, go straight to IDLE: active=0, no done, triggers stay 0, finalize=1.
  - In OPC or DATA, drop the triggers, set finalize=1, go to FIN-abort, wait for m_busy=0 → IDLE. No done pulse, and flags keep the last latched values.
  - abort in IDLE is ignored.
  - If start and abort arrive in the same cycle in IDLE, start wins.
- m_opcode_addr_trigger and m_data_trigger are never high while m_finalize_trigger=1.
- poll_cnt saturates at MAX_POLLS and never wraps. int_cnt resets on every entry to GAP.
- A single status byte is read per CS assertion. The poller does not do continuous RDSR streaming.

Test Plan:
- Master model returns SR=8'h00 on the first read; pulse start → m_opcode_addr_trigger rises 2 clocks later. Then: one RDSR, status_reg=00, flash_busy=0, done pulses once, active=0, m_finalize_trigger=1.
- SR sequence 8'h03, 8'h03, 8'h02 with POLL_INTERVAL=10 → exactly 3 transactions, ≥10 idle clocks between finalize and the next trigger, final flash_wel=1, flash_busy=0, done after the 3rd.
- MAX_POLLS=4, SR always 8'h01 → 4 transactions, then done with timeout=1 and flash_busy=1. A new start clears timeout.
- abort asserted mid DATA → triggers drop, finalize=1, after m_busy=0 active=0 and done never pulses. A following start performs a fresh poll.
- m_busy held high 20 clocks after start → no trigger until m_busy falls, then trigger within 1 clock. A second start during polling is ignored, so the transaction count is unchanged.
- rst asserted while in OPC → next clock: all outputs at reset values, m_finalize_trigger=1, state IDLE.
